// File: rtl/transaccion_multi_pkg.sv
// Shared encodings for the multi-transaction ATM session block:
// transaction types and controller states.
package transaccion_multi_pkg;

   typedef enum logic [1:0] {
      DEPOSITO = 2'b00,
      RETIRO   = 2'b01,
      CONSULTA = 2'b10,
      INVALIDO = 2'b11
   } tipo_t;

   typedef enum logic [2:0] {
      IDLE,
      CARGA,
      ESPERA,
      PROCESA,
      BLOQUEO
   } estado_t;

endpackage

// File: rtl/transaccion_multi_if.sv
// Session bus between the card reader/session controller (master)
// and the transaction block (slave).
interface transaccion_multi_if #(
   parameter int BAL_W   = 64,
   parameter int MONTO_W = 32,
   parameter int NT_W    = 3
);
   logic               tarjeta_recibida;
   logic [BAL_W-1:0]   balance_inicial;
   logic               trans_valida;
   logic [1:0]         tipo_trans;
   logic [MONTO_W-1:0] monto;
   logic               trans_lista;
   logic [BAL_W-1:0]   balance_actualizado;
   logic               balance_stb;
   logic               entregar_dinero;
   logic               fondos_insuficientes;
   logic               limite_excedido;
   logic               error_trans;
   logic [NT_W-1:0]    num_trans;

   modport master (
      output tarjeta_recibida, balance_inicial, trans_valida, tipo_trans, monto,
      input  trans_lista, balance_actualizado, balance_stb, entregar_dinero,
             fondos_insuficientes, limite_excedido, error_trans, num_trans
   );

   modport slave (
      input  tarjeta_recibida, balance_inicial, trans_valida, tipo_trans, monto,
      output trans_lista, balance_actualizado, balance_stb, entregar_dinero,
             fondos_insuficientes, limite_excedido, error_trans, num_trans
   );
endinterface

// File: rtl/transaccion_multi_alu.sv
// Combinational evaluation of one latched transaction: new balance,
// new withdrawn total and the outcome flags.
module transaccion_multi_alu
   import transaccion_multi_pkg::*;
#(
   parameter int               BAL_W         = 64,
   parameter int               MONTO_W       = 32,
   parameter logic [BAL_W-1:0] LIMITE_DIARIO = 500
) (
   input  tipo_t              tipo,
   input  logic [MONTO_W-1:0] monto,
   input  logic [BAL_W-1:0]   balance,
   input  logic [BAL_W-1:0]   retirado,
   output logic [BAL_W-1:0]   balance_next,
   output logic [BAL_W-1:0]   retirado_next,
   output logic               stb,
   output logic               entregar,
   output logic               fondos,
   output logic               limite,
   output logic               error
);
   logic [BAL_W-1:0] monto_ext;
   logic [BAL_W:0]   dep_sum;
   logic [BAL_W:0]   lim_sum;
   logic             monto_cero;

   assign monto_ext  = BAL_W'(monto);
   assign dep_sum    = {1'b0, balance} + {1'b0, monto_ext};
   assign lim_sum    = {1'b0, retirado} + {1'b0, monto_ext};
   assign monto_cero = (monto == '0);

   always_comb begin
      balance_next  = balance;
      retirado_next = retirado;
      stb           = 1'b0;
      entregar      = 1'b0;
      fondos        = 1'b0;
      limite        = 1'b0;
      error         = 1'b0;
      case (tipo)
         DEPOSITO: begin
            if (dep_sum[BAL_W] || monto_cero) begin
               error = 1'b1;
            end else begin
               balance_next = dep_sum[BAL_W-1:0];
               stb          = 1'b1;
            end
         end
         RETIRO: begin
            if (monto_cero) begin
               error = 1'b1;
            end else begin
               // Both refusal reasons are reported together when both apply.
               fondos = (monto_ext > balance);
               limite = (lim_sum > {1'b0, LIMITE_DIARIO});
               if (!fondos && !limite) begin
                  balance_next  = balance - monto_ext;
                  retirado_next = lim_sum[BAL_W-1:0];
                  entregar      = 1'b1;
                  stb           = 1'b1;
               end
            end
         end
         CONSULTA: stb   = 1'b1;
         default:  error = 1'b1;
      endcase
   end
endmodule

// File: rtl/transaccion_multi.sv
// Card-session controller: loads the balance, accepts up to MAX_TRANS
// handshaked transactions, then locks until the card is removed.
module transaccion_multi
   import transaccion_multi_pkg::*;
#(
   parameter int               BAL_W         = 64,
   parameter int               MONTO_W       = 32,
   parameter logic [BAL_W-1:0] LIMITE_DIARIO = 500,
   parameter int               MAX_TRANS     = 4,
   localparam int              NT_W          = $clog2(MAX_TRANS + 1)
) (
   input logic               clk,
   input logic               reset,
   transaccion_multi_if.slave bus
);
   estado_t            state_reg, state_next;
   tipo_t              tipo_reg;
   logic [MONTO_W-1:0] monto_reg;
   logic [BAL_W-1:0]   balance_reg, retirado_reg;
   logic [NT_W-1:0]    num_trans_reg;
   logic               stb_reg, entregar_reg, fondos_reg, limite_reg, error_reg;

   logic [BAL_W-1:0]   alu_balance, alu_retirado;
   logic               alu_stb, alu_entregar, alu_fondos, alu_limite, alu_error;
   logic               accept;

   transaccion_multi_alu #(
      .BAL_W         (BAL_W),
      .MONTO_W       (MONTO_W),
      .LIMITE_DIARIO (LIMITE_DIARIO)
   ) u_alu (
      .tipo          (tipo_reg),
      .monto         (monto_reg),
      .balance       (balance_reg),
      .retirado      (retirado_reg),
      .balance_next  (alu_balance),
      .retirado_next (alu_retirado),
      .stb           (alu_stb),
      .entregar      (alu_entregar),
      .fondos        (alu_fondos),
      .limite        (alu_limite),
      .error         (alu_error)
   );

   // Card removal outranks a simultaneous request.
   assign accept = (state_reg == ESPERA) && bus.tarjeta_recibida && bus.trans_valida;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (bus.tarjeta_recibida) state_next = CARGA;
         CARGA:   state_next = ESPERA;
         ESPERA: begin
            if (!bus.tarjeta_recibida) state_next = IDLE;
            else if (bus.trans_valida) state_next = PROCESA;
         end
         PROCESA: state_next = (num_trans_reg == NT_W'(MAX_TRANS)) ? BLOQUEO : ESPERA;
         BLOQUEO: if (!bus.tarjeta_recibida) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tipo_reg      <= DEPOSITO;
         monto_reg     <= '0;
         balance_reg   <= '0;
         retirado_reg  <= '0;
         num_trans_reg <= '0;
         stb_reg       <= 1'b0;
         entregar_reg  <= 1'b0;
         fondos_reg    <= 1'b0;
         limite_reg    <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         stb_reg      <= 1'b0;
         entregar_reg <= 1'b0;
         fondos_reg   <= 1'b0;
         limite_reg   <= 1'b0;
         error_reg    <= 1'b0;
         case (state_reg)
            CARGA: begin
               balance_reg   <= bus.balance_inicial;
               retirado_reg  <= '0;
               num_trans_reg <= '0;
            end
            ESPERA: begin
               if (accept) begin
                  tipo_reg      <= tipo_t'(bus.tipo_trans);
                  monto_reg     <= bus.monto;
                  num_trans_reg <= num_trans_reg + 1'b1;
               end
            end
            PROCESA: begin
               balance_reg  <= alu_balance;
               retirado_reg <= alu_retirado;
               stb_reg      <= alu_stb;
               entregar_reg <= alu_entregar;
               fondos_reg   <= alu_fondos;
               limite_reg   <= alu_limite;
               error_reg    <= alu_error;
            end
            default: ;
         endcase
      end
   end

   assign bus.trans_lista          = (state_reg == ESPERA);
   assign bus.balance_actualizado  = balance_reg;
   assign bus.balance_stb          = stb_reg;
   assign bus.entregar_dinero      = entregar_reg;
   assign bus.fondos_insuficientes = fondos_reg;
   assign bus.limite_excedido      = limite_reg;
   assign bus.error_trans          = error_reg;
   assign bus.num_trans            = num_trans_reg;
endmodule

// File: tb/tb_transaccion_multi.sv
// Scoreboard bench: the driver predicts each transaction outcome with a
// behavioural account model; a negedge monitor matches every output pulse.
module tb_transaccion_multi;
   import transaccion_multi_pkg::*;

   localparam int          BAL_W     = 64;
   localparam int          MONTO_W   = 32;
   localparam int          MAX_TRANS = 4;
   localparam int          NT_W      = 3;
   localparam logic [63:0] LIMITE    = 64'd500;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   transaccion_multi_if #(.BAL_W(BAL_W), .MONTO_W(MONTO_W), .NT_W(NT_W)) bus ();

   transaccion_multi #(
      .BAL_W         (BAL_W),
      .MONTO_W       (MONTO_W),
      .LIMITE_DIARIO (LIMITE),
      .MAX_TRANS     (MAX_TRANS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // flags = {balance_stb, entregar_dinero, fondos_insuficientes, limite_excedido, error_trans}
   typedef struct {
      logic [4:0]  flags;
      logic [63:0] bal;
      int          n;
      time         due;
      int          id;
   } exp_t;

   exp_t        sb[$];
   int          vectors    = 0;
   int          miscompares = 0;
   int          txn_id     = 0;
   logic [63:0] m_bal, m_ret;
   int          m_cnt;

   task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Account model: session balance, amount withdrawn so far, transaction count.
   task automatic ref_txn(input logic [1:0] t, input logic [31:0] m, output exp_t e);
      logic [64:0] amt;
      logic [64:0] sum;
      logic        no_funds, over_limit;
      amt     = {33'd0, m};
      e.flags = 5'b0;
      m_cnt++;
      case (t)
         2'd0: begin
            sum = {1'b0, m_bal} + amt;
            if (m == 0 || sum[64]) e.flags[0] = 1'b1;
            else begin
               m_bal      = sum[63:0];
               e.flags[4] = 1'b1;
            end
         end
         2'd1: begin
            if (m == 0) e.flags[0] = 1'b1;
            else begin
               no_funds   = amt > {1'b0, m_bal};
               over_limit = ({1'b0, m_ret} + amt) > {1'b0, LIMITE};
               e.flags[2] = no_funds;
               e.flags[1] = over_limit;
               if (!no_funds && !over_limit) begin
                  m_bal      = m_bal - {32'd0, m};
                  m_ret      = m_ret + {32'd0, m};
                  e.flags[4] = 1'b1;
                  e.flags[3] = 1'b1;
               end
            end
         end
         2'd2:    e.flags[4] = 1'b1;
         default: e.flags[0] = 1'b1;
      endcase
      e.bal = m_bal;
      e.n   = m_cnt;
   endtask

   always @(negedge clk) begin
      logic [4:0] f;
      exp_t       e;
      f = {bus.balance_stb, bus.entregar_dinero, bus.fondos_insuficientes,
           bus.limite_excedido, bus.error_trans};
      if (f != 5'b0) begin
         if (sb.size() == 0) begin
            check("spurious_pulse", {60'd0, f}, 65'd0);
         end else begin
            e = sb.pop_front();
            check("flags", {60'd0, f}, {60'd0, e.flags});
            check("balance", {1'b0, bus.balance_actualizado}, {1'b0, e.bal});
            check("num_trans", {62'd0, bus.num_trans}, 65'(e.n));
            check("latency", 65'($time), 65'(e.due));
            $display("txn %0d: flags=%b balance=%0d num_trans=%0d", e.id, f,
                     bus.balance_actualizado, bus.num_trans);
         end
      end
   end

   task automatic check_idle_outputs(input string name);
      check({name, "_lista"}, {64'd0, bus.trans_lista}, 65'd0);
      check({name, "_pulses"}, {60'd0, bus.balance_stb, bus.entregar_dinero,
            bus.fondos_insuficientes, bus.limite_excedido, bus.error_trans}, 65'd0);
      check({name, "_balance"}, {1'b0, bus.balance_actualizado}, 65'd0);
      check({name, "_num"}, {62'd0, bus.num_trans}, 65'd0);
   endtask

   task automatic wait_lista(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.trans_lista) begin
            ok = 1'b1;
            return;
         end
      end
      check("lista_timeout", 65'd0, 65'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 10; i++) begin
         if (sb.size() == 0) return;
         @(negedge clk);
      end
      check("pulse_timeout", 65'(sb.size()), 65'd0);
      sb.delete();
   endtask

   // Called at a negedge with the DUT in IDLE.
   task automatic start_session(input logic [63:0] b);
      bus.balance_inicial  = b;
      bus.tarjeta_recibida = 1'b1;
      m_bal = b;
      m_ret = '0;
      m_cnt = 0;
      @(negedge clk);
      check("carga_lista", {64'd0, bus.trans_lista}, 65'd0);
      @(negedge clk);
      check("espera_lista", {64'd0, bus.trans_lista}, 65'd1);
      check("init_balance", {1'b0, bus.balance_actualizado}, {1'b0, b});
      check("init_num", {62'd0, bus.num_trans}, 65'd0);
      $display("session start: balance=%0d", b);
   endtask

   task automatic end_session();
      bus.tarjeta_recibida = 1'b0;
      @(negedge clk);
      check("idle_lista", {64'd0, bus.trans_lista}, 65'd0);
      @(negedge clk);
   endtask

   task automatic do_txn(input logic [1:0] t, input logic [31:0] m);
      exp_t e;
      bit   ok;
      wait_lista(ok);
      if (!ok) return;
      bus.trans_valida = 1'b1;
      bus.tipo_trans   = t;
      bus.monto        = m;
      ref_txn(t, m, e);
      @(posedge clk);
      txn_id++;
      e.id  = txn_id;
      e.due = $time + 15;
      sb.push_back(e);
      #1;
      // Scramble the request lines: only the accept edge may matter.
      bus.trans_valida = 1'b0;
      bus.tipo_trans   = 2'($urandom);
      bus.monto        = $urandom;
      drain();
   endtask

   task automatic bloqueo_probe();
      check("bloqueo_lista", {64'd0, bus.trans_lista}, 65'd0);
      bus.trans_valida = 1'b1;
      bus.tipo_trans   = 2'd2;
      bus.monto        = 32'd1;
      repeat (4) @(negedge clk);
      bus.trans_valida = 1'b0;
      check("bloqueo_num", {62'd0, bus.num_trans}, 65'(MAX_TRANS));
      check("bloqueo_lista_hold", {64'd0, bus.trans_lista}, 65'd0);
   endtask

   initial begin
      logic [31:0] amt;
      logic [63:0] b;
      int          n;
      bit          ok;
      bus.tarjeta_recibida = 1'b0;
      bus.balance_inicial  = '0;
      bus.trans_valida     = 1'b0;
      bus.tipo_trans       = 2'd0;
      bus.monto            = '0;
      #2 reset = 1'b1;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b0;
      @(negedge clk);

      // Deposit, withdrawals, limit, lock.
      start_session(64'd1000);
      do_txn(2'd0, 32'd100);
      do_txn(2'd1, 32'd50);
      do_txn(2'd1, 32'd2000);
      do_txn(2'd1, 32'd460);
      bloqueo_probe();
      end_session();

      // Overflow and error cases.
      start_session(64'hFFFF_FFFF_FFFF_FFF6);
      do_txn(2'd0, 32'd20);
      do_txn(2'd3, 32'd5);
      do_txn(2'd1, 32'd0);
      do_txn(2'd0, 32'd0);
      bloqueo_probe();
      end_session();

      // Asynchronous reset during PROCESA.
      start_session(64'd1000);
      wait_lista(ok);
      bus.trans_valida = 1'b1;
      bus.tipo_trans   = 2'd1;
      bus.monto        = 32'd100;
      @(posedge clk);
      #1;
      bus.trans_valida     = 1'b0;
      bus.tarjeta_recibida = 1'b0;
      reset                = 1'b1;
      sb.delete();
      #1;
      check_idle_outputs("async_reset");
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("post_reset");

      // Card removed in the same cycle as a request.
      start_session(64'd777);
      bus.tarjeta_recibida = 1'b0;
      bus.trans_valida     = 1'b1;
      bus.tipo_trans       = 2'd0;
      bus.monto            = 32'd5;
      @(posedge clk);
      #1;
      bus.trans_valida = 1'b0;
      check("removal_lista", {64'd0, bus.trans_lista}, 65'd0);
      check("removal_num", {62'd0, bus.num_trans}, 65'd0);
      repeat (3) @(negedge clk);
      check("removal_balance_held", {1'b0, bus.balance_actualizado}, 65'd777);

      // Randomised sessions.
      for (int s = 0; s < 14; s++) begin
         if ($urandom_range(0, 3) == 0) b = {32'hFFFF_FFFF, $urandom};
         else                           b = 64'($urandom_range(0, 3000));
         start_session(b);
         n = $urandom_range(1, MAX_TRANS);
         for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 9))
               0:       amt = 32'd0;
               8:       amt = $urandom_range(1, 3000);
               9:       amt = $urandom;
               default: amt = $urandom_range(1, 700);
            endcase
            do_txn(2'($urandom_range(0, 3)), amt);
         end
         if (n == MAX_TRANS) bloqueo_probe();
         end_session();
      end

      drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
